// File: rtl/exu_bju_pkg.sv
// rtl/exu_bju_pkg.sv - shared widths, payload field offsets and queue entry type for the BJU issue queue
package exu_bju_pkg;

    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 157;

    // Payload is packed MSB-first: iid, pdst, pdst_vld, imm_vld, imm, pc, funct3, funct7, opcode
    localparam int OPCODE_LSB   = 0;
    localparam int FUNCT7_LSB   = 7;
    localparam int FUNCT3_LSB   = 14;
    localparam int PC_LSB       = 17;
    localparam int IMM_LSB      = 81;
    localparam int IMM_VLD_BIT  = 145;
    localparam int PDST_VLD_BIT = 146;
    localparam int PDST_LSB     = 147;
    localparam int IID_LSB      = 153;

    typedef struct packed {
        logic                 valid;
        logic                 rdy1;
        logic                 rdy2;
        logic [PREG_W-1:0]    preg1;
        logic [PREG_W-1:0]    preg2;
        logic [PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    function automatic logic [63:0] payload_pc(input logic [PAYLOAD_W-1:0] payload);
        return payload[PC_LSB +: 64];
    endfunction

endpackage

// File: rtl/exu_bju_iq_if.sv
// rtl/exu_bju_iq_if.sv - dispatch and issue handshake bundle of the BJU issue queue
interface exu_bju_iq_if #(
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 157
);
    logic                 disp_vld;
    logic                 disp_rdy;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [PREG_W-1:0]    disp_psrc1_preg;
    logic                 disp_psrc1_rdy;
    logic [PREG_W-1:0]    disp_psrc2_preg;
    logic                 disp_psrc2_rdy;
    logic                 issue_vld;
    logic                 issue_rdy;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [PREG_W-1:0]    issue_psrc1_preg;
    logic [PREG_W-1:0]    issue_psrc2_preg;

    modport master (
        output disp_vld, disp_payload, disp_psrc1_preg, disp_psrc1_rdy,
               disp_psrc2_preg, disp_psrc2_rdy, issue_rdy,
        input  disp_rdy, issue_vld, issue_payload, issue_psrc1_preg, issue_psrc2_preg
    );

    modport slave (
        input  disp_vld, disp_payload, disp_psrc1_preg, disp_psrc1_rdy,
               disp_psrc2_preg, disp_psrc2_rdy, issue_rdy,
        output disp_rdy, issue_vld, issue_payload, issue_psrc1_preg, issue_psrc2_preg
    );
endinterface

// File: rtl/exu_bju_iq_entry.sv
// rtl/exu_bju_iq_entry.sv - one issue queue slot with writeback wakeup of its source ready bits
module exu_bju_iq_entry
    import exu_bju_pkg::*;
(
    input  logic              clk,
    input  logic              rst_clk,
    input  logic              flush,
    input  logic              wr_en,
    input  iq_entry_t         wr_data,
    input  logic              pop,
    input  logic              wb_vld,
    input  logic [PREG_W-1:0] wb_preg,
    output iq_entry_t         entry
);

    always_ff @(posedge clk) begin
        if (rst_clk || flush) begin
            entry <= '0;
        end else if (wr_en) begin
            entry <= wr_data;
        end else begin
            if (pop)
                entry.valid <= 1'b0;
            if (entry.valid && wb_vld && (wb_preg == entry.preg1))
                entry.rdy1 <= 1'b1;
            if (entry.valid && wb_vld && (wb_preg == entry.preg2))
                entry.rdy2 <= 1'b1;
        end
    end

endmodule

// File: rtl/exu_bju_iq.sv
// rtl/exu_bju_iq.sv - in-order BJU issue queue; EXU_BJU_IQ_BYPASS_EN enables empty-queue dispatch-to-issue bypass
module exu_bju_iq #(
    parameter int DEPTH     = 4,
    parameter int PREG_W    = exu_bju_pkg::PREG_W,
    parameter int PAYLOAD_W = exu_bju_pkg::PAYLOAD_W
) (
    input  logic                     clk,
    input  logic                     rst_clk,
    input  logic                     rtu_global_flush,
    input  logic                     wb_vld,
    input  logic [PREG_W-1:0]        wb_preg,
    output logic [$clog2(DEPTH):0]   iq_count,
    exu_bju_iq_if.slave              bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   q_issue;
    logic                   disp_rdy1;
    logic                   disp_rdy2;
    exu_bju_pkg::iq_entry_t wr_data;
    exu_bju_pkg::iq_entry_t head_e;
    exu_bju_pkg::iq_entry_t entries [DEPTH];

    assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    assign empty    = (head == tail);
    assign iq_count = tail - head;
    assign bus.disp_rdy = !full;

    // Wakeup arriving in the dispatch cycle must not be lost on the entry being written
    assign disp_rdy1 = bus.disp_psrc1_rdy || (wb_vld && (wb_preg == bus.disp_psrc1_preg));
    assign disp_rdy2 = bus.disp_psrc2_rdy || (wb_vld && (wb_preg == bus.disp_psrc2_preg));

    always_comb begin
        wr_data         = '0;
        wr_data.valid   = 1'b1;
        wr_data.rdy1    = disp_rdy1;
        wr_data.rdy2    = disp_rdy2;
        wr_data.preg1   = bus.disp_psrc1_preg;
        wr_data.preg2   = bus.disp_psrc2_preg;
        wr_data.payload = bus.disp_payload;
    end

    assign head_e  = entries[head[IDX_W-1:0]];
    assign q_issue = head_e.valid && head_e.rdy1 && head_e.rdy2 && !rtu_global_flush;
    assign pop     = q_issue && bus.issue_rdy;

`ifdef EXU_BJU_IQ_BYPASS_EN
    logic bypass;

    assign bypass = empty && bus.disp_vld && disp_rdy1 && disp_rdy2 && !rtu_global_flush;
    assign push   = bus.disp_vld && bus.disp_rdy && !rtu_global_flush && !(bypass && bus.issue_rdy);

    always_comb begin
        bus.issue_vld        = q_issue || bypass;
        bus.issue_payload    = head_e.payload;
        bus.issue_psrc1_preg = head_e.preg1;
        bus.issue_psrc2_preg = head_e.preg2;
        if (bypass) begin
            bus.issue_payload    = bus.disp_payload;
            bus.issue_psrc1_preg = bus.disp_psrc1_preg;
            bus.issue_psrc2_preg = bus.disp_psrc2_preg;
        end
    end
`else
    logic unused_empty;

    assign unused_empty = empty;
    assign push         = bus.disp_vld && bus.disp_rdy && !rtu_global_flush;

    always_comb begin
        bus.issue_vld        = q_issue;
        bus.issue_payload    = head_e.payload;
        bus.issue_psrc1_preg = head_e.preg1;
        bus.issue_psrc2_preg = head_e.preg2;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_clk || rtu_global_flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            tail <= tail + PTR_W'(push);
            head <= head + PTR_W'(pop);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        exu_bju_iq_entry u_entry (
            .clk     (clk),
            .rst_clk (rst_clk),
            .flush   (rtu_global_flush),
            .wr_en   (push && (tail[IDX_W-1:0] == IDX_W'(i))),
            .wr_data (wr_data),
            .pop     (pop && (head[IDX_W-1:0] == IDX_W'(i))),
            .wb_vld  (wb_vld),
            .wb_preg (wb_preg),
            .entry   (entries[i])
        );
    end

endmodule

// File: tb/tb_exu_bju_iq.sv
// tb/tb_exu_bju_iq.sv - directed vector bench for the BJU issue queue (default build)
module tb_exu_bju_iq;

    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 157;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst_clk;
    logic        rtu_global_flush;
    logic        wb_vld;
    logic [5:0]  wb_preg;
    logic [2:0]  iq_count;
    int          tests = 0;
    int          fails = 0;

    exu_bju_iq_if #(.PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    exu_bju_iq #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk              (clk),
        .rst_clk          (rst_clk),
        .rtu_global_flush (rtu_global_flush),
        .wb_vld           (wb_vld),
        .wb_preg          (wb_preg),
        .iq_count         (iq_count),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic flush, dv;
        int   iid;
        int   p1; logic r1;
        int   p2; logic r2;
        logic wbv; int wbp;
        logic irdy;
        logic e_drdy, e_iv;
        int   e_iid, e_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mkv(logic flush, logic dv, int iid, int p1, logic r1, int p2, logic r2,
                                 logic wbv, int wbp, logic irdy, logic e_drdy, logic e_iv, int e_iid, int e_cnt);
        vec_t v;
        v.flush = flush; v.dv = dv; v.iid = iid; v.p1 = p1; v.r1 = r1; v.p2 = p2; v.r2 = r2;
        v.wbv = wbv; v.wbp = wbp; v.irdy = irdy;
        v.e_drdy = e_drdy; v.e_iv = e_iv; v.e_iid = e_iid; v.e_cnt = e_cnt;
        return v;
    endfunction

    function automatic logic [63:0] pc_of(int iid);
        return 64'h1000 + 64'(iid - 1) * 64'd4;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] mk_payload(int iid);
        logic [3:0] id;
        id = 4'(iid);
        return {id, 6'd0, 1'b0, 1'b0, 64'd0, pc_of(iid), 3'd0, 7'd0, 7'h63};
    endfunction

    task automatic chk(string name, int idx, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic drive(logic flush, logic dv, int iid, int p1, logic r1, int p2, logic r2,
                         logic wbv, int wbp, logic irdy);
        rtu_global_flush    = flush;
        bus.disp_vld        = dv;
        bus.disp_payload    = mk_payload(iid);
        bus.disp_psrc1_preg = 6'(p1);
        bus.disp_psrc1_rdy  = r1;
        bus.disp_psrc2_preg = 6'(p2);
        bus.disp_psrc2_rdy  = r2;
        wb_vld              = wbv;
        wb_preg             = 6'(wbp);
        bus.issue_rdy       = irdy;
    endtask

    task automatic idle(logic irdy);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, irdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle(1'b0);
        rst_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_clk = 1'b0;
    endtask

    int exp_q[$];
    int pops;
    int max_cnt;

    initial begin
        rst_clk = 1'b1;
        idle(1'b0);
        do_reset();
        #1;
        chk("rst_payload", 0, 64'(bus.issue_payload[63:0]), 64'd0);
        chk("rst_psrc1", 0, 64'(bus.issue_psrc1_preg), 64'd0);
        chk("rst_psrc2", 0, 64'(bus.issue_psrc2_preg), 64'd0);

        //             fl dv iid p1 r1 p2 r2 wbv wbp irdy drdy iv iid cnt
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
        tv.push_back(mkv(0, 1, 1, 1, 1, 2, 1, 0, 0, 0,  1, 0, 0, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
        // blocked head on preg 5 must hold back a ready younger op
        tv.push_back(mkv(0, 1, 2, 5, 0, 3, 1, 0, 0, 1,  1, 0, 0, 0));
        tv.push_back(mkv(0, 1, 3, 1, 1, 2, 1, 0, 0, 1,  1, 0, 0, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 2));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 5, 1,  1, 0, 0, 2));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 2, 2));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 3, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
        // same-cycle wakeup on src2=7
        tv.push_back(mkv(0, 1, 4, 1, 1, 7, 0, 1, 7, 0,  1, 0, 0, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 4, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 4, 1));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
        // fill to full, then refused dispatch alongside a pop
        tv.push_back(mkv(0, 1, 5, 1, 1, 2, 1, 0, 0, 0,  1, 0, 0, 0));
        tv.push_back(mkv(0, 1, 6, 1, 1, 2, 1, 0, 0, 0,  1, 1, 5, 1));
        tv.push_back(mkv(0, 1, 7, 1, 1, 2, 1, 0, 0, 0,  1, 1, 5, 2));
        tv.push_back(mkv(0, 1, 8, 1, 1, 2, 1, 0, 0, 0,  1, 1, 5, 3));
        tv.push_back(mkv(0, 1, 9, 1, 1, 2, 1, 0, 0, 1,  0, 1, 5, 4));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 6, 3));
        // flush with three queued and a dispatch in the same cycle
        tv.push_back(mkv(1, 1, 10, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 3));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));
        tv.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].flush, tv[i].dv, tv[i].iid, tv[i].p1, tv[i].r1, tv[i].p2, tv[i].r2,
                  tv[i].wbv, tv[i].wbp, tv[i].irdy);
            #1;
            chk("disp_rdy", i, 64'(bus.disp_rdy), 64'(tv[i].e_drdy));
            chk("issue_vld", i, 64'(bus.issue_vld), 64'(tv[i].e_iv));
            chk("iq_count", i, 64'(iq_count), 64'(tv[i].e_cnt));
            if (tv[i].e_iv) begin
                chk("issue_iid", i, 64'(bus.issue_payload[156:153]), 64'(tv[i].e_iid));
                chk("issue_pc", i, bus.issue_payload[80:17], pc_of(tv[i].e_iid));
            end
        end

        // full-rate push/pop across two pointer wraps, iid 0..9
        pops = 0;
        max_cnt = 0;
        exp_q.delete();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c < 10) begin
                drive(1'b0, 1'b1, c, 1, 1'b1, 2, 1'b1, 1'b0, 0, 1'b1);
                exp_q.push_back(c);
            end else begin
                idle(1'b1);
            end
            #1;
            if (int'(iq_count) > max_cnt) max_cnt = int'(iq_count);
            if (bus.issue_vld) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", c, 64'd1, 64'd0);
                end else begin
                    chk("stream_iid", c, 64'(bus.issue_payload[156:153]), 64'(exp_q[0]));
                    exp_q.pop_front();
                    pops++;
                end
            end
        end
        chk("stream_pops", 0, 64'(pops), 64'd10);
        chk("stream_maxcnt_le4", 0, 64'(max_cnt <= 4), 64'd1);

        // reset in the middle of operation drops queued ops and the concurrent dispatch
        @(negedge clk);
        drive(1'b0, 1'b1, 11, 9, 1'b1, 10, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 12, 1, 1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
        #1;
        chk("psrc1_head", 0, 64'(bus.issue_psrc1_preg), 64'd9);
        chk("psrc2_head", 0, 64'(bus.issue_psrc2_preg), 64'd10);
        @(negedge clk);
        drive(1'b0, 1'b1, 13, 1, 1'b1, 2, 1'b1, 1'b0, 0, 1'b1);
        rst_clk = 1'b1;
        @(negedge clk);
        rst_clk = 1'b0;
        idle(1'b1);
        #1;
        chk("rst_mid_count", 0, 64'(iq_count), 64'd0);
        chk("rst_mid_issue_vld", 0, 64'(bus.issue_vld), 64'd0);
        chk("rst_mid_disp_rdy", 0, 64'(bus.disp_rdy), 64'd1);
        @(negedge clk);
        #1;
        chk("rst_mid_issue_vld2", 1, 64'(bus.issue_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/exu_bju_iq.md
EXU_BJU_IQ -- requirements
Module: exu_bju_iq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; only powers of two from 2 to 16 are legal.
REQ-002 The block SHALL have parameter PREG_W, default 6, giving the physical register index width.
REQ-003 The block SHALL have parameter PAYLOAD_W, default 157, giving the packed op width: iid 4, pdst 6, pdst_vld 1, imm_vld 1, imm 64, pc 64, funct3 3, funct7 7, opcode 7.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_clk  in  1  synchronous active-high reset.
- rtu_global_flush  in  1  discards every queued op.
- disp_vld  in  1  dispatch request.
- disp_rdy  out  1  queue can accept a dispatch.
- disp_payload  in  PAYLOAD_W  packed op.
- disp_psrc1_preg  in  PREG_W  source 1 physical register.
- disp_psrc1_rdy  in  1  source 1 value available.
- disp_psrc2_preg  in  PREG_W  source 2 physical register.
- disp_psrc2_rdy  in  1  source 2 value available.
- wb_vld  in  1  writeback wakeup strobe.
- wb_preg  in  PREG_W  register being woken.
- issue_vld  out  1  head op issuable to the BJU.
- issue_rdy  in  1  BJU accepts the op.
- issue_payload  out  PAYLOAD_W  head op fields.
- issue_psrc1_preg  out  PREG_W  register-file read index for source 1.
- issue_psrc2_preg  out  PREG_W  register-file read index for source 2.
- iq_count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-006 The queue SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH)+1 bits, the extra bit being a wrap bit; full is defined as equal index with differing wrap bits, and empty as both pointers equal.
REQ-007 disp_rdy SHALL be !full, computed combinationally; a push SHALL occur on disp_vld & disp_rdy & !rtu_global_flush.
REQ-008 A pushed entry SHALL store its payload, both pregs, and its ready bits; each ready bit SHALL also be set if wb_vld is high in the push cycle and wb_preg matches that source (same-cycle wakeup bypass).
REQ-009 Each cycle, for every valid entry, a source ready bit SHALL be set when wb_vld is high and wb_preg equals that source's preg.
REQ-010 Issue SHALL be strictly in order: issue_vld = head valid & src1 ready & src2 ready & !rtu_global_flush; a younger ready op SHALL never bypass a blocked head.
REQ-011 issue_payload and both issue_psrc*_preg outputs SHALL reflect the head entry combinationally; a pop SHALL occur on issue_vld & issue_rdy.
REQ-012 The minimum dispatch-to-issue latency SHALL be 1 cycle, i.e. issue_vld is high in the cycle after the push.
REQ-013 A push and a pop in the same cycle SHALL both take effect and leave iq_count unchanged; when full, disp_rdy SHALL stay 0 even if a pop occurs that cycle.
REQ-014 Pointers SHALL wrap modulo DEPTH while toggling the wrap bit; iq_count SHALL equal tail minus head.
REQ-015 While issue_vld is high and issue_rdy is low, the head and all issue outputs SHALL hold stable.
REQ-016 When rtu_global_flush is high, the next state SHALL be empty (pointers 0, all valid bits 0); in the flush cycle the push is ignored and issue_vld is 0.

Reset
REQ-017 On rst_clk sampled high, the block SHALL clear head, tail and all valid and ready bits; in the following cycle disp_rdy=1, issue_vld=0, iq_count=0, and issue_payload and the issue pregs=0.
REQ-018 Reset SHALL take priority over flush, push, pop and wakeup; reset asserted mid-operation SHALL drop all queued ops.

Configuration
REQ-019 With EXU_BJU_IQ_BYPASS_EN defined and the queue empty, a push whose sources are both ready (after the wakeup bypass) SHALL drive issue_vld and the issue outputs combinationally from the dispatch inputs; on issue_rdy the op SHALL NOT be enqueued, giving 0-cycle latency.
REQ-020 Without EXU_BJU_IQ_BYPASS_EN, the behaviour SHALL be exactly as REQ-012, with no dispatch-to-issue combinational path.

Structure
REQ-021 Package exu_bju_pkg SHALL hold PREG_W, PAYLOAD_W, the payload field offsets and the entry struct type (valid, rdy1, rdy2, preg1, preg2, payload).
REQ-022 Per-entry storage and wakeup compare SHALL be in sub-module exu_bju_iq_entry, instantiated DEPTH times.

Verification
REQ-023 The bench SHALL cover: after reset, dispatch an op with pc=0x1000 and both sources ready -> issue_vld=1 next cycle (or the same cycle with the bypass macro), payload pc=0x1000.
REQ-024 The bench SHALL cover: dispatch an op with src1 preg 5 not ready, then an op with both sources ready -> no issue until wb_vld with wb_preg=5, then both issue in order on consecutive cycles.
REQ-025 The bench SHALL cover: four dispatches with issue_rdy=0 -> iq_count=4 and disp_rdy=0; then issue_rdy=1 with a new dispatch -> that dispatch is refused that cycle, one pop, iq_count=3.
REQ-026 The bench SHALL cover: a dispatch whose src2=7 coincides with wb_vld and wb_preg=7 -> the entry is stored ready, and issue_vld goes high next cycle.
REQ-027 The bench SHALL cover: three entries queued, assert rtu_global_flush together with disp_vld -> next cycle iq_count=0 and issue_vld=0, and the flushed dispatch never issues.
REQ-028 The bench SHALL cover: 10 push/pop cycles at full rate with DEPTH=4 -> pointers wrap, issue order equals dispatch order (iid 0..9), and iq_count never exceeds 4.
